fp_mul_normalize_pipe: RTL and testbench

- Pipeline stage directly downstream of the FP multiplier's multiply stage, inside the inverse-square-root datapath.
- Consumes the raw 48-bit significand product, the unbiased exponent sum and the pass-through operand.
- Normalizes, rounds to nearest-even, re-biases, saturates/flushes, and emits a 31-bit unsigned float (exponent + mantissa, no sign).
- Two internal register stages sharing the global backpressure stall.

---
 rtl/fp_pkg.sv | 12 +
 rtl/fp_round_rne.sv | 35 +++
 rtl/fp_mul_normalize_pipe.sv | 163 ++++++++++++++++
 tb/tb_fp_mul_normalize_pipe.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants for the FP multiplier normalize/round datapath
// Purpose: widths and exponent limits used by fp_mul_normalize_pipe and fp_round_rne.
// Ports: none (package).
package fp_pkg;

  localparam int EXP_BIAS = 127;  // IEEE-754 single-precision bias
  localparam int EXP_MAX  = 255;  // biased exponent reserved for saturation
  localparam int MANT_W   = 23;   // stored mantissa width (hidden one dropped)
  localparam int PROD_W   = 48;   // {1,M1}*{1,M2} product width
  localparam int EXT_EW   = 10;   // signed internal exponent width, headroom for +1 +1 +bias

endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - combinational round-to-nearest-even increment with exponent carry
// Purpose: adds the rounding increment to a 23-bit mantissa and bumps the exponent on carry-out.
// Ports:
//   mant   in  23        truncated mantissa (hidden one excluded)
//   guard  in  1         first discarded bit
//   sticky in  1         OR of all bits below guard
//   e      in  EXT_EW    signed unbiased exponent
//   m_r    out 23        rounded mantissa (wraps to 0 on carry)
//   e_adj  out EXT_EW    exponent after carry
//   carry  out 1         mantissa overflowed into the exponent
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int EXT_EW = fp_pkg::EXT_EW
) (
  input  logic [MANT_W-1:0]        mant,
  input  logic                     guard,
  input  logic                     sticky,
  input  logic signed [EXT_EW-1:0] e,
  output logic [MANT_W-1:0]        m_r,
  output logic signed [EXT_EW-1:0] e_adj,
  output logic                     carry
);

  logic round_up;

  // Exact ties (guard set, nothing below) only round up when that makes the LSB even.
  assign round_up = guard & (sticky | mant[0]);

  // All-ones mantissa plus one carries out; the mantissa field becomes zero and the
  // significand 2.0 is represented by the incremented exponent.
  assign {carry, m_r} = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
  assign e_adj        = e + {{(EXT_EW-1){1'b0}}, carry};

endmodule

// File: rtl/fp_mul_normalize_pipe.sv
// rtl/fp_mul_normalize_pipe.sv - two-stage normalize/round/re-bias stage after the FP multiply
// Purpose: normalizes the 48-bit significand product, rounds (nearest-even when
//   FP_MUL_ROUND_NEAREST_EN is defined, truncation otherwise), re-biases, saturates
//   overflow to {FF,0} and flushes underflow to zero. Two register stages, common stall.
// Ports:
//   clk         in  1   clock
//   rstn        in  1   synchronous active-low reset (clears valid/error only)
//   backprn     in  1   0 = stall all registers, 1 = advance
//   valid       in  1   upstream data valid
//   M_mul       in  48  significand product in [2^46, 2^48)
//   E_mul       in  8   signed unbiased exponent sum
//   float_in_2  in  31  pass-through operand
//   error_in    in  1   upstream error
//   float_out   out 31  {exp[7:0], mant[22:0]}
//   float_out_2 out 31  float_in_2 aligned with float_out
//   ready       out 1   float_out valid
//   error_out   out 1   error_in | overflow | underflow, qualified by ready
module fp_mul_normalize_pipe
  import fp_pkg::*;
#(
  parameter int EXP_BIAS = fp_pkg::EXP_BIAS,
  parameter int EXT_EW   = fp_pkg::EXT_EW
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              backprn,
  input  logic              valid,
  input  logic [PROD_W-1:0] M_mul,
  input  logic [7:0]        E_mul,
  input  logic [30:0]       float_in_2,
  input  logic              error_in,
  output logic [30:0]       float_out,
  output logic [30:0]       float_out_2,
  output logic              ready,
  output logic              error_out
);

  localparam logic signed [EXT_EW-1:0] BIAS_E = EXT_EW'(EXP_BIAS);
  localparam logic signed [EXT_EW-1:0] MAX_E  = EXT_EW'(EXP_MAX);
  localparam logic signed [EXT_EW-1:0] ZERO_E = '0;
  localparam logic signed [EXT_EW-1:0] ONE_E  = EXT_EW'(1);

  // ---------------- stage 1: normalize ----------------
  logic [MANT_W-1:0]        mant_n;
  logic signed [EXT_EW-1:0] e_sext;
  logic signed [EXT_EW-1:0] e_n;

  assign e_sext = {{(EXT_EW-8){E_mul[7]}}, E_mul};

  // Product of two [1,2) significands lies in [1,4): bit 47 set means the value is
  // >= 2.0, so shift one further right and account for it in the exponent.
  always_comb begin
    mant_n = M_mul[45:23];
    e_n    = e_sext;
    if (M_mul[47]) begin
      mant_n = M_mul[46:24];
      e_n    = e_sext + ONE_E;
    end
  end

  logic                     v1;
  logic                     err1;
  logic [30:0]              f2_1;
  logic [MANT_W-1:0]        mant1;
  logic signed [EXT_EW-1:0] e1;
  logic                     guard_r;
  logic                     sticky_r;

`ifdef FP_MUL_ROUND_NEAREST_EN
  logic guard_n;
  logic sticky_n;
  logic guard1;
  logic sticky1;

  assign guard_n  = M_mul[47] ? M_mul[23]  : M_mul[22];
  assign sticky_n = M_mul[47] ? |M_mul[22:0] : |M_mul[21:0];

  always_ff @(posedge clk) begin
    if (backprn && valid) begin
      guard1  <= guard_n;
      sticky1 <= sticky_n;
    end
  end

  assign guard_r  = guard1;
  assign sticky_r = sticky1;
`else
  // Truncation: bits below the kept mantissa are simply dropped.
  logic unused_prod_lsbs;
  assign unused_prod_lsbs = ^M_mul[22:0];
  assign guard_r  = 1'b0;
  assign sticky_r = 1'b0;
`endif

  // ---------------- stage 2: round, re-bias, saturate ----------------
  logic [MANT_W-1:0]        m_r;
  logic signed [EXT_EW-1:0] e_adj;
  logic                     carry;
  logic signed [EXT_EW-1:0] biased;
  logic                     overflow;
  logic                     underflow;
  logic [30:0]              float_n;

  fp_round_rne #(
    .EXT_EW (EXT_EW)
  ) u_round (
    .mant   (mant1),
    .guard  (guard_r),
    .sticky (sticky_r),
    .e      (e1),
    .m_r    (m_r),
    .e_adj  (e_adj),
    .carry  (carry)
  );

  assign biased    = e_adj + BIAS_E;
  assign overflow  = (biased >= MAX_E);
  assign underflow = (biased <= ZERO_E);  // no denormals: flush

  always_comb begin
    float_n = {biased[7:0], m_r};
    if (overflow) begin
      float_n = {8'hFF, {MANT_W{1'b0}}};
    end else if (underflow) begin
      float_n = '0;
    end
  end

  // carry only feeds the exponent; keep it visible as a named net
  logic unused_carry;
  assign unused_carry = carry;

  // ---------------- control registers (reset) ----------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1        <= 1'b0;
      err1      <= 1'b0;
      ready     <= 1'b0;
      error_out <= 1'b0;
    end else if (backprn) begin
      v1        <= valid;
      err1      <= valid & error_in;
      ready     <= v1;
      error_out <= v1 & (err1 | overflow | underflow);
    end
  end

  // ---------------- data registers (no reset) ----------------
  always_ff @(posedge clk) begin
    if (backprn) begin
      if (valid) begin
        f2_1  <= float_in_2;
        mant1 <= mant_n;
        e1    <= e_n;
      end
      if (v1) begin
        float_out   <= float_n;
        float_out_2 <= f2_1;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_normalize_pipe.sv
// tb/tb_fp_mul_normalize_pipe.sv - self-checking bench for fp_mul_normalize_pipe
module tb_fp_mul_normalize_pipe;

  typedef struct {
    logic [47:0] m;
    logic [7:0]  e;
    logic        err_in;
    logic [30:0] f2;
    logic [30:0] exp_f;
    logic        exp_err;
  } vec_t;

  localparam int NV = 13;

  logic        clk = 1'b0;
  logic        rstn;
  logic        backprn;
  logic        valid;
  logic [47:0] M_mul;
  logic [7:0]  E_mul;
  logic [30:0] float_in_2;
  logic        error_in;
  logic [30:0] float_out;
  logic [30:0] float_out_2;
  logic        ready;
  logic        error_out;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  fp_mul_normalize_pipe dut (
    .clk         (clk),
    .rstn        (rstn),
    .backprn     (backprn),
    .valid       (valid),
    .M_mul       (M_mul),
    .E_mul       (E_mul),
    .float_in_2  (float_in_2),
    .error_in    (error_in),
    .float_out   (float_out),
    .float_out_2 (float_out_2),
    .ready       (ready),
    .error_out   (error_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic vld);
    M_mul      = v.m;
    E_mul      = v.e;
    error_in   = v.err_in;
    float_in_2 = v.f2;
    valid      = vld;
  endtask

  task automatic chk_out(input string name, input vec_t v);
    chk({name, ".ready"}, {31'd0, ready}, 32'd1);
    chk({name, ".float_out"}, {1'b0, float_out}, {1'b0, v.exp_f});
    chk({name, ".float_out_2"}, {1'b0, float_out_2}, {1'b0, v.f2});
    chk({name, ".error_out"}, {31'd0, error_out}, {31'd0, v.exp_err});
  endtask

  initial begin
    // m, e, err_in, f2, expected float, expected error
    vecs[0]  = '{48'h4000_0000_0000, 8'h00, 1'b0, 31'h0, 31'h3F80_0000, 1'b0};  // 1.0*1.0
    vecs[1]  = '{48'h9000_0000_0000, 8'h00, 1'b0, 31'h0, 31'h4010_0000, 1'b0};  // 1.5*1.5
    vecs[2]  = '{48'h4000_0040_0000, 8'h00, 1'b0, 31'h0, 31'h3F80_0000, 1'b0};  // tie, even lsb
`ifdef FP_MUL_ROUND_NEAREST_EN
    vecs[3]  = '{48'h4000_00C0_0000, 8'h00, 1'b0, 31'h0, 31'h3F80_0002, 1'b0};  // tie, odd lsb
    vecs[4]  = '{48'h7FFF_FFFF_FFFF, 8'h00, 1'b0, 31'h0, 31'h4000_0000, 1'b0};  // mantissa carry
    vecs[10] = '{48'h7FFF_FFFF_FFFF, 8'h7F, 1'b0, 31'h0, 31'h7F80_0000, 1'b1};  // carry into overflow
    vecs[12] = '{48'h8000_0080_0001, 8'h00, 1'b0, 31'h0, 31'h4000_0001, 1'b0};  // above half
`else
    vecs[3]  = '{48'h4000_00C0_0000, 8'h00, 1'b0, 31'h0, 31'h3F80_0001, 1'b0};
    vecs[4]  = '{48'h7FFF_FFFF_FFFF, 8'h00, 1'b0, 31'h0, 31'h3FFF_FFFF, 1'b0};
    vecs[10] = '{48'h7FFF_FFFF_FFFF, 8'h7F, 1'b0, 31'h0, 31'h7F7F_FFFF, 1'b0};
    vecs[12] = '{48'h8000_0080_0001, 8'h00, 1'b0, 31'h0, 31'h4000_0000, 1'b0};
`endif
    vecs[5]  = '{48'h8000_0000_0000, 8'h7F, 1'b0, 31'h0, 31'h7F80_0000, 1'b1};  // overflow
    vecs[6]  = '{48'h4000_0000_0000, 8'h81, 1'b0, 31'h0, 31'h0000_0000, 1'b1};  // underflow (-127)
    vecs[7]  = '{48'h4000_0000_0000, 8'h7F, 1'b0, 31'h0, 31'h7F00_0000, 1'b0};  // largest exponent
    vecs[8]  = '{48'h4000_0000_0000, 8'h82, 1'b0, 31'h0, 31'h0080_0000, 1'b0};  // smallest exponent
    vecs[9]  = '{48'h9000_0000_0000, 8'h00, 1'b1, 31'h0, 31'h4010_0000, 1'b1};  // error_in
    vecs[11] = '{48'h8000_0000_0000, 8'h80, 1'b0, 31'h0, 31'h0000_0000, 1'b1};  // -128+1 underflow
    for (int i = 0; i < NV; i++) vecs[i].f2 = 31'h1234_5600 + 31'(i);

    // reset
    rstn = 1'b0; backprn = 1'b1;
    drive(vecs[0], 1'b0);
    tick(); tick();
    chk("reset.ready", {31'd0, ready}, 32'd0);
    chk("reset.error_out", {31'd0, error_out}, 32'd0);
    rstn = 1'b1;
    tick();

    // single-shot: exact 2-cycle latency, one-cycle ready pulse
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i], 1'b1);
      tick();
      valid = 1'b0;
      chk($sformatf("single%0d.early_ready", i), {31'd0, ready}, 32'd0);
      tick();
      chk_out($sformatf("single%0d", i), vecs[i]);
      tick();
      chk($sformatf("single%0d.ready_drop", i), {31'd0, ready}, 32'd0);
      chk($sformatf("single%0d.err_drop", i), {31'd0, error_out}, 32'd0);
    end

    // back-to-back stream, no bubbles
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) drive(vecs[i], 1'b1);
      else valid = 1'b0;
      tick();
      if (i >= 1) chk_out($sformatf("stream%0d", i - 1), vecs[i - 1]);
    end
    tick();
    chk("stream.end_ready", {31'd0, ready}, 32'd0);

    // stall: A B, 3 stalled cycles with junk on the inputs, then C D
    drive(vecs[1], 1'b1); tick();
    drive(vecs[5], 1'b1); tick();
    chk_out("stall.a_pre", vecs[1]);
    backprn = 1'b0;
    drive(vecs[12], 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("stall.hold%0d", k), vecs[1]);
    end
    backprn = 1'b1;
    drive(vecs[7], 1'b1); tick();
    chk_out("stall.b", vecs[5]);
    drive(vecs[9], 1'b1); tick();
    chk_out("stall.c", vecs[7]);
    valid = 1'b0; tick();
    chk_out("stall.d", vecs[9]);
    tick();
    chk("stall.end_ready", {31'd0, ready}, 32'd0);

    // reset with two items in flight, asserted during a stall
    drive(vecs[5], 1'b1); tick();
    drive(vecs[1], 1'b1); tick();
    chk_out("rst.pre", vecs[5]);
    rstn = 1'b0; backprn = 1'b0;
    drive(vecs[9], 1'b1);
    tick();
    chk("rst.ready", {31'd0, ready}, 32'd0);
    chk("rst.error_out", {31'd0, error_out}, 32'd0);
    rstn = 1'b1; backprn = 1'b1; valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst.after%0d.ready", k), {31'd0, ready}, 32'd0);
      chk($sformatf("rst.after%0d.error_out", k), {31'd0, error_out}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
